// File: rtl/dy_frame_sched.sv
// dy_frame_sched: collects host command bytes into 128-bit DY instruction frames
// and replays each loaded frame to the modulator: on for frame_len clocks, off for
// gap_len clocks, repeated cfg_repeat times. A shadow buffer fills while the
// active frame is being sent.
// Optional build macro DY_FRAME_CRC_EN: 17-byte frames whose last byte is a CRC-8
// (poly 0x07, init 0x00, MSB first) over bytes 0..15; adds the err_crc port.
module dy_frame_sched #(
  parameter int U_DLY   = 1,
  parameter int TIMER_W = 24
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [TIMER_W-1:0] cfg_frame_len,
  input  logic [TIMER_W-1:0] cfg_gap_len,
  input  logic [7:0]         cfg_repeat,
  input  logic               cfg_abort,
  input  logic               cmd_valid,
  input  logic               cmd_sof,
  input  logic [7:0]         cmd_data,
  output logic               cmd_ready,
  output logic               dy_tx_en,
  output logic [127:0]       dy_tx_data,
  output logic               frame_done,
  output logic               err_frame,
`ifdef DY_FRAME_CRC_EN
  output logic               err_crc,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // Index of the byte that completes a frame (the CRC byte when checking is on).
`ifdef DY_FRAME_CRC_EN
  localparam logic [4:0] LAST_IDX = 5'd16;
`else
  localparam logic [4:0] LAST_IDX = 5'd15;
`endif

  // U_DLY is accepted for drop-in compatibility; registers update without delay.
  if (U_DLY < 0) begin : g_u_dly_unused
  end

  state_t               state_reg, state_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [7:0]           rep_cnt_reg, rep_cnt_next;
  logic [TIMER_W-1:0]   frame_len_reg, frame_len_next;
  logic [TIMER_W-1:0]   gap_len_reg, gap_len_next;
  logic [7:0]           repeat_reg, repeat_next;
  logic [127:0]         tx_data_reg, tx_data_next;
  logic                 tx_en_reg, done_reg, done_next, busy_reg, ready_reg;
  logic [127:0]         shadow_reg, shadow_next;
  logic                 shadow_full_reg, shadow_full_next;
  logic [4:0]           idx_reg, idx_next;
  logic [15:0]          wr_en;
  logic                 set_full, load, err_frame_reg, err_frame_next;
  logic                 accept;
`ifdef DY_FRAME_CRC_EN
  logic [7:0]           crc_reg, crc_next;
  logic                 err_crc_reg, err_crc_next;

  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  assign accept = cmd_valid & ready_reg;

  // Byte collection: index tracking, framing errors and frame completion.
  always_comb begin
    idx_next       = idx_reg;
    wr_en          = '0;
    set_full       = 1'b0;
    err_frame_next = 1'b0;
`ifdef DY_FRAME_CRC_EN
    crc_next       = crc_reg;
    err_crc_next   = 1'b0;
`endif
    if (cfg_abort) begin
      idx_next = 5'd0;
    end else if (accept) begin
      if (cmd_sof) begin
        // SOF always restarts the frame; a partial frame in progress is an error.
        err_frame_next = (idx_reg != 5'd0);
        wr_en[0]       = 1'b1;
        idx_next       = 5'd1;
`ifdef DY_FRAME_CRC_EN
        crc_next       = crc8_upd(8'h00, cmd_data);
`endif
      end else if (idx_reg == 5'd0) begin
        err_frame_next = 1'b1;
      end else if (idx_reg == LAST_IDX) begin
        idx_next = 5'd0;
`ifdef DY_FRAME_CRC_EN
        if (cmd_data == crc_reg) set_full = 1'b1;
        else                     err_crc_next = 1'b1;
`else
        wr_en[15] = 1'b1;
        set_full  = 1'b1;
`endif
      end else begin
        wr_en[idx_reg[3:0]] = 1'b1;
        idx_next            = idx_reg + 5'd1;
`ifdef DY_FRAME_CRC_EN
        crc_next            = crc8_upd(crc_reg, cmd_data);
`endif
      end
    end
  end

  // Byte 0 lands in the MSB lane; abort wipes the whole shadow.
  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    assign shadow_next[127-8*gi -: 8] = cfg_abort ? 8'h00 :
                                        (wr_en[gi] ? cmd_data : shadow_reg[127-8*gi -: 8]);
  end

  // A load empties the shadow; completion fills it (the two never coincide).
  assign shadow_full_next = !cfg_abort & (set_full | (shadow_full_reg & !load));

  // Scheduler next-state: IDLE waits for a frame, SEND/GAP time the repeats.
  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    rep_cnt_next   = rep_cnt_reg;
    frame_len_next = frame_len_reg;
    gap_len_next   = gap_len_reg;
    repeat_next    = repeat_reg;
    tx_data_next   = tx_data_reg;
    done_next      = 1'b0;
    load           = 1'b0;
    if (cfg_abort) begin
      state_next   = S_IDLE;
      timer_next   = '0;
      rep_cnt_next = 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: load = shadow_full_reg;
        S_SEND: begin
          if (timer_reg == frame_len_reg - TIMER_W'(1)) begin
            state_next = S_GAP;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + TIMER_W'(1);
          end
        end
        S_GAP: begin
          if (timer_reg == gap_len_reg - TIMER_W'(1)) begin
            rep_cnt_next = rep_cnt_reg + 8'd1;
            timer_next   = '0;
            if (({1'b0, rep_cnt_reg} + 9'd1) < {1'b0, repeat_reg}) begin
              state_next = S_SEND;
            end else begin
              done_next = 1'b1;
              // Chain straight into the waiting frame without an IDLE cycle.
              if (shadow_full_reg) load = 1'b1;
              else                 state_next = S_IDLE;
            end
          end else begin
            timer_next = timer_reg + TIMER_W'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    if (load) begin
      tx_data_next   = shadow_reg;
      frame_len_next = (cfg_frame_len == '0) ? TIMER_W'(1) : cfg_frame_len;
      gap_len_next   = (cfg_gap_len == '0) ? TIMER_W'(1) : cfg_gap_len;
      repeat_next    = (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
      rep_cnt_next   = 8'd0;
      timer_next     = '0;
      state_next     = S_SEND;
    end
  end

  // State and registered outputs; reset also clears the active frame data.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      timer_reg       <= '0;
      rep_cnt_reg     <= 8'd0;
      frame_len_reg   <= TIMER_W'(1);
      gap_len_reg     <= TIMER_W'(1);
      repeat_reg      <= 8'd1;
      tx_data_reg     <= '0;
      tx_en_reg       <= 1'b0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      ready_reg       <= 1'b1;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      idx_reg         <= 5'd0;
      err_frame_reg   <= 1'b0;
`ifdef DY_FRAME_CRC_EN
      crc_reg         <= 8'h00;
      err_crc_reg     <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      rep_cnt_reg     <= rep_cnt_next;
      frame_len_reg   <= frame_len_next;
      gap_len_reg     <= gap_len_next;
      repeat_reg      <= repeat_next;
      tx_data_reg     <= tx_data_next;
      tx_en_reg       <= (state_next == S_SEND);
      done_reg        <= done_next;
      busy_reg        <= (state_next != S_IDLE) | shadow_full_next;
      ready_reg       <= !shadow_full_next;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      idx_reg         <= idx_next;
      err_frame_reg   <= err_frame_next;
`ifdef DY_FRAME_CRC_EN
      crc_reg         <= crc_next;
      err_crc_reg     <= err_crc_next;
`endif
    end
  end

  assign cmd_ready  = ready_reg;
  assign dy_tx_en   = tx_en_reg;
  assign dy_tx_data = tx_data_reg;
  assign frame_done = done_reg;
  assign err_frame  = err_frame_reg;
  assign busy       = busy_reg;
`ifdef DY_FRAME_CRC_EN
  assign err_crc    = err_crc_reg;
`endif

endmodule

// File: tb/tb_dy_frame_sched.sv
// Scoreboard bench for dy_frame_sched: each driven frame pushes its expected
// transmit pulses; a negedge monitor pops and checks them as they appear.
module tb_dy_frame_sched;
  localparam int TIMER_W = 24;

  logic               clk_sys, rst_n;
  logic [TIMER_W-1:0] cfg_frame_len, cfg_gap_len;
  logic [7:0]         cfg_repeat;
  logic               cfg_abort, cmd_valid, cmd_sof;
  logic [7:0]         cmd_data;
  logic               cmd_ready, dy_tx_en, frame_done, err_frame, busy;
  logic [127:0]       dy_tx_data;
`ifdef DY_FRAME_CRC_EN
  logic               err_crc;
`endif

  dy_frame_sched #(.U_DLY(1), .TIMER_W(TIMER_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cfg_frame_len(cfg_frame_len), .cfg_gap_len(cfg_gap_len),
    .cfg_repeat(cfg_repeat), .cfg_abort(cfg_abort),
    .cmd_valid(cmd_valid), .cmd_sof(cmd_sof), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .dy_tx_en(dy_tx_en), .dy_tx_data(dy_tx_data),
    .frame_done(frame_done), .err_frame(err_frame),
`ifdef DY_FRAME_CRC_EN
    .err_crc(err_crc),
`endif
    .busy(busy)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  typedef struct {
    logic [127:0] data;
    int           len;
    int           gap_before;  // -1: not checked
    bit           last;        // frame_done expected after this pulse's gap
    int           gap_after;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   done_cnt = 0, err_cnt = 0, crc_cnt = 0;
  bit   mon_en = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] frame_of(input logic [7:0] base);
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f = {f[119:0], 8'(base + i)};
    return f;
  endfunction

  // Serial bit-at-a-time CRC-8, poly 0x07, init 0, MSB first.
  function automatic logic [7:0] crc_of(input logic [7:0] base);
    logic [7:0] c, b;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b = 8'(base + i);
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic sof);
    int guard;
    guard = 0;
    @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_data = b; cmd_sof = sof;
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 2000) check_val("ready_timeout", 0, 1);
    @(posedge clk_sys);
    #1;
    cmd_valid = 1'b0; cmd_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] crc_xor);
    for (int i = 0; i < 16; i++) send_byte(8'(base + i), (i == 0));
`ifdef DY_FRAME_CRC_EN
    send_byte(crc_of(base) ^ crc_xor, 1'b0);
`else
    if (crc_xor != 8'h00) $display("[TB] crc_xor ignored without CRC build");
`endif
  endtask

  task automatic push_frame(input logic [7:0] base, input int len, input int gap,
                            input int rep, input int first_gap);
    exp_t e;
    for (int k = 0; k < rep; k++) begin
      e.data = frame_of(base); e.len = len; e.gap_after = gap;
      e.gap_before = (k == 0) ? first_gap : gap;
      e.last = (k == rep - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk_sys);
    while ((busy || dy_tx_en) && guard < 1000) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 1000) check_val("idle_timeout", 0, 1);
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wait_tx_en();
    int guard;
    guard = 0;
    @(negedge clk_sys);
    while (!dy_tx_en && guard < 200) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 200) check_val("tx_en_timeout", 0, 1);
  endtask

  // Monitor: measures each dy_tx_en pulse, the low gap before it and frame_done timing.
  initial begin
    exp_t e;
    logic [127:0] start_data;
    bit en_prev, stable;
    int run, low_cnt, rise_low, since_fall, pending_gap;
    en_prev = 0; stable = 1; run = 0; low_cnt = 0; rise_low = 0;
    since_fall = 0; pending_gap = -1; start_data = '0;
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        since_fall++;
        if (err_frame) err_cnt++;
`ifdef DY_FRAME_CRC_EN
        if (err_crc) crc_cnt++;
`endif
        if (dy_tx_en) begin
          if (!en_prev) begin
            run = 1; start_data = dy_tx_data; stable = 1; rise_low = low_cnt;
          end else begin
            run++;
            if (dy_tx_data !== start_data) stable = 0;
          end
        end else begin
          if (en_prev) begin
            if (exp_q.size() == 0) check_val("sb_unexpected_pulse", 1, 0);
            else begin
              e = exp_q.pop_front();
              check_val("sb_data", start_data, e.data);
              check_val("sb_len", run, e.len);
              check_val("sb_stable", stable, 1);
              if (e.gap_before >= 0) check_val("sb_gap", rise_low, e.gap_before);
              pending_gap = e.last ? e.gap_after : -1;
              $display("[TB] pulse data=%0h len=%0d gap_before=%0d", start_data, run, rise_low);
            end
            since_fall = 1; low_cnt = 0;
          end
          low_cnt++;
        end
        if (frame_done) begin
          done_cnt++;
          if (pending_gap < 0) check_val("done_unexpected", 1, 0);
          else check_val("done_timing", since_fall, pending_gap + 1);
          pending_gap = -1;
        end
        en_prev = dy_tx_en;
      end else begin
        en_prev = 0;
      end
    end
  end

  initial begin
    int d0, e0;
    exp_t e;
    rst_n = 1'b0; cfg_abort = 1'b0; cmd_valid = 1'b0; cmd_sof = 1'b0; cmd_data = 8'h00;
    cfg_frame_len = 24'd8; cfg_gap_len = 24'd4; cfg_repeat = 8'd1;
    repeat (3) @(negedge clk_sys);
    check_val("rst_tx_en", dy_tx_en, 0);
    check_val("rst_tx_data", dy_tx_data, 0);
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_err_frame", err_frame, 0);
    rst_n = 1'b1;
    mon_en = 1;

    // T1: single send, latency and constant frame image
    d0 = done_cnt;
    push_frame(8'h00, 8, 4, 1, -1);
    send_frame(8'h00, 8'h00);
    @(negedge clk_sys);
    check_val("t1_en_n1", dy_tx_en, 0);
    check_val("t1_ready_n1", cmd_ready, 0);
    check_val("t1_busy_n1", busy, 1);
    @(negedge clk_sys);
    check_val("t1_en_n2", dy_tx_en, 1);
    check_val("t1_data", dy_tx_data, 128'h000102030405060708090A0B0C0D0E0F);
    wait_idle();
    check_val("t1_done_cnt", done_cnt - d0, 1);
    $display("[TB] T1 single frame complete");

    // T2: three repeats of the same frame
    d0 = done_cnt;
    cfg_repeat = 8'd3;
    push_frame(8'h00, 8, 4, 3, -1);
    send_frame(8'h00, 8'h00);
    wait_idle();
    check_val("t2_done_cnt", done_cnt - d0, 1);
    $display("[TB] T2 repeat frame complete");

    // T3: frame B collected while A sends; B inherits no new config until its load
    d0 = done_cnt;
    cfg_frame_len = 24'd20; cfg_gap_len = 24'd4; cfg_repeat = 8'd1;
    push_frame(8'h40, 20, 4, 1, -1);
    push_frame(8'hF0, 6, 3, 1, 4);
    send_frame(8'h40, 8'h00);
    @(posedge clk_sys);
    #1;
    cfg_frame_len = 24'd6; cfg_gap_len = 24'd3;
    send_frame(8'hF0, 8'h00);
    @(negedge clk_sys);
    check_val("t3_ready_low", cmd_ready, 0);
    check_val("t3_tx_en_a", dy_tx_en, 1);
    wait_idle();
    check_val("t3_ready_back", cmd_ready, 1);
    check_val("t3_done_cnt", done_cnt - d0, 2);
    $display("[TB] T3 double buffer complete");

    // T4: SOF at index 10 restarts; then a stray non-SOF byte at index 0
    cfg_frame_len = 24'd8; cfg_gap_len = 24'd4;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i), (i == 0));
    push_frame(8'h20, 8, 4, 1, -1);
    send_frame(8'h20, 8'h00);
    wait_idle();
    check_val("t4_err_cnt", err_cnt - e0, 1);
    check_val("t4_done_cnt", done_cnt - d0, 1);
    e0 = err_cnt;
    send_byte(8'h77, 1'b0);
    repeat (3) @(negedge clk_sys);
    check_val("t4_nosof_err", err_cnt - e0, 1);
    check_val("t4_nosof_busy", busy, 0);
    $display("[TB] T4 framing errors complete");

    // T5: abort on the third SEND clock
    d0 = done_cnt;
    e.data = frame_of(8'h30); e.len = 3; e.gap_before = -1; e.last = 0; e.gap_after = 0;
    exp_q.push_back(e);
    send_frame(8'h30, 8'h00);
    wait_tx_en();
    @(negedge clk_sys);
    @(negedge clk_sys);
    cfg_abort = 1'b1;
    @(posedge clk_sys);
    #1;
    cfg_abort = 1'b0;
    @(negedge clk_sys);
    check_val("t5_tx_en", dy_tx_en, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_ready", cmd_ready, 1);
    check_val("t5_data_kept", dy_tx_data, frame_of(8'h30));
    // abort also flushes a partial frame: the next SOF must not flag an error
    for (int i = 0; i < 3; i++) send_byte(8'(8'h90 + i), (i == 0));
    @(negedge clk_sys);
    cfg_abort = 1'b1;
    @(posedge clk_sys);
    #1;
    cfg_abort = 1'b0;
    e0 = err_cnt;
    push_frame(8'hA0, 8, 4, 1, -1);
    send_frame(8'hA0, 8'h00);
    wait_idle();
    check_val("t5_flush_err", err_cnt - e0, 0);
    check_val("t5_done_cnt", done_cnt - d0, 1);
    $display("[TB] T5 abort complete");

`ifdef DY_FRAME_CRC_EN
    // T6: good CRC frame sent, corrupted CRC dropped
    e0 = crc_cnt;
    push_frame(8'h00, 8, 4, 1, -1);
    send_frame(8'h00, 8'h00);
    wait_idle();
    send_frame(8'h00, 8'h01);
    repeat (30) @(negedge clk_sys);
    check_val("t6_crc_err", crc_cnt - e0, 1);
    check_val("t6_busy", busy, 0);
    $display("[TB] T6 crc complete");
`endif

    check_val("sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-frame clears the active data too
    mon_en = 0;
    send_frame(8'h60, 8'h00);
    wait_tx_en();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_tx_en", dy_tx_en, 0);
    check_val("arst_tx_data", dy_tx_data, 0);
    check_val("arst_ready", cmd_ready, 1);
    check_val("arst_busy", busy, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    $display("[TB] async reset complete");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
